// File: rtl/axilite_master_if.sv
// AXI4-Lite bus bundle between axilite_master and a register-bank slave.
// The master modport drives addresses, data, valids and BREADY/RREADY.
interface axilite_master_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   AWADDR;
    logic                    AWVALID;
    logic                    AWREADY;
    logic [DATA_WIDTH-1:0]   WDATA;
    logic [DATA_WIDTH/8-1:0] WSTRB;
    logic                    WVALID;
    logic                    WREADY;
    logic [1:0]              BRESP;
    logic                    BVALID;
    logic                    BREADY;
    logic [ADDR_WIDTH-1:0]   ARADDR;
    logic                    ARVALID;
    logic                    ARREADY;
    logic [DATA_WIDTH-1:0]   RDATA;
    logic [1:0]              RRESP;
    logic                    RVALID;
    logic                    RREADY;

    modport master (
        output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );

    modport slave (
        input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );
endinterface

// File: rtl/axilite_master.sv
// Single-outstanding AXI4-Lite master: one valid/ready command in, one response beat out.
// Every output is a flop; next values are derived from the next FSM state.
module axilite_master #(
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_M_AXI_ADDR_WIDTH = 12,
    parameter int C_CNT_WIDTH        = 16
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESETN,
    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic                              cmd_write,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic                              rsp_write,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                        rsp_resp,
    output logic [C_CNT_WIDTH-1:0]            wr_count,
    output logic [C_CNT_WIDTH-1:0]            rd_count,
    output logic [C_CNT_WIDTH-1:0]            err_count,
    axilite_master_if.master                  m_axi
);
    localparam int AW = C_M_AXI_ADDR_WIDTH;
    localparam int DW = C_M_AXI_DATA_WIDTH;
    localparam int SW = C_M_AXI_DATA_WIDTH / 8;
    localparam logic [C_CNT_WIDTH-1:0] CNT_ONE = 1;

    typedef enum logic [2:0] {
        IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RSP
    } state_t;

    state_t        state_reg, state_next;
    logic [AW-1:0] addr_reg, addr_next;
    logic [DW-1:0] wdata_reg, wdata_next;
    logic [SW-1:0] wstrb_reg, wstrb_next;
    logic          aw_done_reg, aw_done_next;
    logic          w_done_reg, w_done_next;
    logic          rsp_write_reg, rsp_write_next;
    logic [DW-1:0] rsp_rdata_reg, rsp_rdata_next;
    logic [1:0]    rsp_resp_reg, rsp_resp_next;

    logic          cmd_ready_reg, cmd_ready_next;
    logic          awvalid_reg, awvalid_next;
    logic          wvalid_reg, wvalid_next;
    logic          bready_reg, bready_next;
    logic          arvalid_reg, arvalid_next;
    logic          rready_reg, rready_next;
    logic          rsp_valid_reg, rsp_valid_next;
    logic [AW-1:0] awaddr_reg, awaddr_next;
    logic [AW-1:0] araddr_reg, araddr_next;
    logic [DW-1:0] wdata_out_reg, wdata_out_next;
    logic [SW-1:0] wstrb_out_reg, wstrb_out_next;

    always_comb begin
        state_next     = state_reg;
        addr_next      = addr_reg;
        wdata_next     = wdata_reg;
        wstrb_next     = wstrb_reg;
        aw_done_next   = aw_done_reg;
        w_done_next    = w_done_reg;
        rsp_write_next = rsp_write_reg;
        rsp_rdata_next = rsp_rdata_reg;
        rsp_resp_next  = rsp_resp_reg;

        case (state_reg)
            IDLE: begin
                if (cmd_valid && cmd_ready_reg) begin
                    addr_next      = cmd_addr;
                    wdata_next     = cmd_wdata;
                    wstrb_next     = cmd_wstrb;
                    rsp_write_next = cmd_write;
                    aw_done_next   = 1'b0;
                    w_done_next    = 1'b0;
                    state_next     = cmd_write ? WR_ADDR_DATA : RD_ADDR;
                end
            end
            WR_ADDR_DATA: begin
                // AW and W complete independently; leave only once both have.
                if (awvalid_reg && m_axi.AWREADY) aw_done_next = 1'b1;
                if (wvalid_reg && m_axi.WREADY)   w_done_next  = 1'b1;
                if (aw_done_next && w_done_next)  state_next   = WR_RESP;
            end
            WR_RESP: begin
                if (bready_reg && m_axi.BVALID) begin
                    rsp_rdata_next = '0;
                    rsp_resp_next  = m_axi.BRESP;
                    state_next     = RSP;
                end
            end
            RD_ADDR: begin
                if (arvalid_reg && m_axi.ARREADY) state_next = RD_DATA;
            end
            RD_DATA: begin
                if (rready_reg && m_axi.RVALID) begin
                    rsp_rdata_next = m_axi.RDATA;
                    rsp_resp_next  = m_axi.RRESP;
                    state_next     = RSP;
                end
            end
            RSP: begin
                if (rsp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        cmd_ready_next = (state_next == IDLE);
        awvalid_next   = (state_next == WR_ADDR_DATA) && !aw_done_next;
        wvalid_next    = (state_next == WR_ADDR_DATA) && !w_done_next;
        bready_next    = (state_next == WR_RESP);
        arvalid_next   = (state_next == RD_ADDR);
        rready_next    = (state_next == RD_DATA);
        rsp_valid_next = (state_next == RSP);
        // Bus payloads are zero whenever their channel is not presenting.
        awaddr_next    = awvalid_next ? addr_next  : '0;
        araddr_next    = arvalid_next ? addr_next  : '0;
        wdata_out_next = wvalid_next  ? wdata_next : '0;
        wstrb_out_next = wvalid_next  ? wstrb_next : '0;
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state_reg     <= IDLE;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            wstrb_reg     <= '0;
            aw_done_reg   <= 1'b0;
            w_done_reg    <= 1'b0;
            rsp_write_reg <= 1'b0;
            rsp_rdata_reg <= '0;
            rsp_resp_reg  <= '0;
            cmd_ready_reg <= 1'b0;
            awvalid_reg   <= 1'b0;
            wvalid_reg    <= 1'b0;
            bready_reg    <= 1'b0;
            arvalid_reg   <= 1'b0;
            rready_reg    <= 1'b0;
            rsp_valid_reg <= 1'b0;
            awaddr_reg    <= '0;
            araddr_reg    <= '0;
            wdata_out_reg <= '0;
            wstrb_out_reg <= '0;
        end else begin
            state_reg     <= state_next;
            addr_reg      <= addr_next;
            wdata_reg     <= wdata_next;
            wstrb_reg     <= wstrb_next;
            aw_done_reg   <= aw_done_next;
            w_done_reg    <= w_done_next;
            rsp_write_reg <= rsp_write_next;
            rsp_rdata_reg <= rsp_rdata_next;
            rsp_resp_reg  <= rsp_resp_next;
            cmd_ready_reg <= cmd_ready_next;
            awvalid_reg   <= awvalid_next;
            wvalid_reg    <= wvalid_next;
            bready_reg    <= bready_next;
            arvalid_reg   <= arvalid_next;
            rready_reg    <= rready_next;
            rsp_valid_reg <= rsp_valid_next;
            awaddr_reg    <= awaddr_next;
            araddr_reg    <= araddr_next;
            wdata_out_reg <= wdata_out_next;
            wstrb_out_reg <= wstrb_out_next;
        end
    end

    // Counters: 0 = writes, 1 = reads, 2 = error responses; all stick at all-ones.
    logic       rsp_fire;
    logic [2:0] cnt_inc;

    assign rsp_fire   = rsp_valid_reg && rsp_ready;
    assign cnt_inc[0] = rsp_fire && rsp_write_reg;
    assign cnt_inc[1] = rsp_fire && !rsp_write_reg;
    assign cnt_inc[2] = rsp_fire && (rsp_resp_reg != 2'b00);

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_cnt
            logic [C_CNT_WIDTH-1:0] cnt_reg;
            always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
                if (!S_AXI_ARESETN) begin
                    cnt_reg <= '0;
                end else if (cnt_inc[gi] && !(&cnt_reg)) begin
                    cnt_reg <= cnt_reg + CNT_ONE;
                end
            end
        end
    endgenerate

    assign wr_count  = g_cnt[0].cnt_reg;
    assign rd_count  = g_cnt[1].cnt_reg;
    assign err_count = g_cnt[2].cnt_reg;

    assign cmd_ready     = cmd_ready_reg;
    assign rsp_valid     = rsp_valid_reg;
    assign rsp_write     = rsp_write_reg;
    assign rsp_rdata     = rsp_rdata_reg;
    assign rsp_resp      = rsp_resp_reg;
    assign m_axi.AWADDR  = awaddr_reg;
    assign m_axi.AWVALID = awvalid_reg;
    assign m_axi.WDATA   = wdata_out_reg;
    assign m_axi.WSTRB   = wstrb_out_reg;
    assign m_axi.WVALID  = wvalid_reg;
    assign m_axi.BREADY  = bready_reg;
    assign m_axi.ARADDR  = araddr_reg;
    assign m_axi.ARVALID = arvalid_reg;
    assign m_axi.RREADY  = rready_reg;
endmodule

// File: tb/tb_axilite_master.sv
// Bench for axilite_master: delay-configurable AXI4-Lite slave, word-level reference memory,
// directed scenarios followed by randomized commands.
module tb_axilite_master;
    localparam int AW   = 12;
    localparam int DW   = 32;
    localparam int CW   = 6;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic [3:0]    cmd_wstrb = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic          rsp_write;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;
    logic [CW-1:0] wr_count, rd_count, err_count;

    axilite_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m_axi ();

    axilite_master #(
        .C_M_AXI_DATA_WIDTH(DW),
        .C_M_AXI_ADDR_WIDTH(AW),
        .C_CNT_WIDTH(CW)
    ) dut (
        .S_AXI_ACLK(clk),
        .S_AXI_ARESETN(rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata),
        .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp),
        .wr_count(wr_count),
        .rd_count(rd_count),
        .err_count(err_count),
        .m_axi(m_axi)
    );

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    // ---------------- slave model (reset on the same net) ----------------
    int         aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
    logic [1:0] resp_cfg = 2'b00;
    logic [31:0] smem [0:1023];
    logic        got_aw, got_w, r_pend;
    logic [AW-1:0] s_awaddr, s_araddr;
    logic [31:0]   s_wdata;
    logic [3:0]    s_wstrb;
    int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    int aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_axi.AWREADY <= 1'b0; m_axi.WREADY <= 1'b0; m_axi.ARREADY <= 1'b0;
            m_axi.BVALID <= 1'b0; m_axi.BRESP <= 2'b00;
            m_axi.RVALID <= 1'b0; m_axi.RRESP <= 2'b00; m_axi.RDATA <= '0;
            got_aw <= 1'b0; got_w <= 1'b0; r_pend <= 1'b0;
            s_awaddr <= '0; s_araddr <= '0; s_wdata <= '0; s_wstrb <= '0;
            aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
            for (int i = 0; i < 1024; i++) smem[i] <= '0;
        end else begin
            // Ready is pre-asserted only for zero delay, otherwise counted from VALID.
            if (m_axi.AWREADY && m_axi.AWVALID) begin
                got_aw <= 1'b1; s_awaddr <= m_axi.AWADDR; m_axi.AWREADY <= 1'b0;
                aw_cnt <= 0; aw_hs <= aw_hs + 1;
            end else if (!got_aw) begin
                if (!m_axi.AWVALID) begin
                    m_axi.AWREADY <= (aw_delay == 0); aw_cnt <= 0;
                end else if (!m_axi.AWREADY) begin
                    if (aw_cnt + 1 >= aw_delay) m_axi.AWREADY <= 1'b1;
                    aw_cnt <= aw_cnt + 1;
                end
            end
            if (m_axi.WREADY && m_axi.WVALID) begin
                got_w <= 1'b1; s_wdata <= m_axi.WDATA; s_wstrb <= m_axi.WSTRB;
                m_axi.WREADY <= 1'b0; w_cnt <= 0; w_hs <= w_hs + 1;
            end else if (!got_w) begin
                if (!m_axi.WVALID) begin
                    m_axi.WREADY <= (w_delay == 0); w_cnt <= 0;
                end else if (!m_axi.WREADY) begin
                    if (w_cnt + 1 >= w_delay) m_axi.WREADY <= 1'b1;
                    w_cnt <= w_cnt + 1;
                end
            end
            if (m_axi.BVALID) begin
                if (m_axi.BREADY) begin m_axi.BVALID <= 1'b0; b_hs <= b_hs + 1; end
            end else if (got_aw && got_w) begin
                if (b_cnt >= b_delay) begin
                    m_axi.BVALID <= 1'b1; m_axi.BRESP <= resp_cfg;
                    if (resp_cfg == 2'b00)
                        smem[s_awaddr[11:2]] <= merge(smem[s_awaddr[11:2]], s_wdata, s_wstrb);
                    got_aw <= 1'b0; got_w <= 1'b0; b_cnt <= 0;
                end else b_cnt <= b_cnt + 1;
            end
            if (m_axi.ARREADY && m_axi.ARVALID) begin
                r_pend <= 1'b1; s_araddr <= m_axi.ARADDR; m_axi.ARREADY <= 1'b0;
                ar_cnt <= 0; ar_hs <= ar_hs + 1;
            end else if (!r_pend && !m_axi.RVALID) begin
                if (!m_axi.ARVALID) begin
                    m_axi.ARREADY <= (ar_delay == 0); ar_cnt <= 0;
                end else if (!m_axi.ARREADY) begin
                    if (ar_cnt + 1 >= ar_delay) m_axi.ARREADY <= 1'b1;
                    ar_cnt <= ar_cnt + 1;
                end
            end
            if (m_axi.RVALID) begin
                if (m_axi.RREADY) begin m_axi.RVALID <= 1'b0; r_hs <= r_hs + 1; end
            end else if (r_pend) begin
                if (r_cnt >= r_delay) begin
                    m_axi.RVALID <= 1'b1; m_axi.RDATA <= smem[s_araddr[11:2]];
                    m_axi.RRESP <= resp_cfg; r_pend <= 1'b0; r_cnt <= 0;
                end else r_cnt <= r_cnt + 1;
            end
        end
    end

    // ---------------- bus monitors ----------------
    int aw_only_cycles = 0, w_only_cycles = 0, stab_err = 0;
    logic aw_wait, w_wait;
    logic [AW-1:0] prev_awaddr;
    logic [DW-1:0] prev_wdata;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_wait <= 1'b0; w_wait <= 1'b0; prev_awaddr <= '0; prev_wdata <= '0;
        end else begin
            if (m_axi.AWVALID && !m_axi.WVALID) aw_only_cycles <= aw_only_cycles + 1;
            if (m_axi.WVALID && !m_axi.AWVALID) w_only_cycles <= w_only_cycles + 1;
            if (aw_wait && (!m_axi.AWVALID || m_axi.AWADDR != prev_awaddr)) stab_err <= stab_err + 1;
            if (w_wait && (!m_axi.WVALID || m_axi.WDATA != prev_wdata)) stab_err <= stab_err + 1;
            aw_wait     <= m_axi.AWVALID && !m_axi.AWREADY;
            w_wait      <= m_axi.WVALID && !m_axi.WREADY;
            prev_awaddr <= m_axi.AWADDR;
            prev_wdata  <= m_axi.WDATA;
        end
    end

    // ---------------- reference model and checking ----------------
    logic [31:0] mmem [0:1023];
    int wr_exp = 0, rd_exp = 0, err_exp = 0;
    int tests = 0, fails = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v < CMAX) ? v + 1 : v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 1024; i++) mmem[i] = '0;
        wr_exp = 0; rd_exp = 0; err_exp = 0;
    endtask

    task automatic run_cmd(input bit wr, input logic [AW-1:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic [1:0] resp, input int hold,
                           input string tag);
        logic [31:0] exp_rdata;
        int n, aw0, w0, b0, ar0, r0;
        aw0 = aw_hs; w0 = w_hs; b0 = b_hs; ar0 = ar_hs; r0 = r_hs;
        if (wr) begin
            exp_rdata = '0;
            if (resp == 2'b00) mmem[addr[11:2]] = merge(mmem[addr[11:2]], data, strb);
        end else begin
            exp_rdata = mmem[addr[11:2]];
        end
        resp_cfg  = resp;
        cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb; cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
        check({tag, "_accept"}, 32'(cmd_ready), 32'd1);
        if (!cmd_ready) begin cmd_valid = 1'b0; return; end
        @(negedge clk);
        cmd_valid = 1'b0;
        check({tag, "_busy"}, 32'(cmd_ready), 32'd0);
        n = 0;
        while (!rsp_valid && n < 200) begin @(negedge clk); n++; end
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
        if (!rsp_valid) return;
        for (int i = 0; i < hold; i++) begin
            check({tag, "_hold_rdata"}, rsp_rdata, exp_rdata);
            check({tag, "_hold_resp"}, 32'(rsp_resp), 32'(resp));
            check({tag, "_hold_cmd_ready"}, 32'(cmd_ready), 32'd0);
            check({tag, "_hold_wr_count"}, 32'(wr_count), 32'(wr_exp));
            // a stray command pulse while busy must be ignored
            cmd_valid = (i == 2); cmd_write = 1'b1; cmd_addr = 12'hFFC;
            cmd_wdata = 32'hBAD0BAD0; cmd_wstrb = 4'hF;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        check({tag, "_rsp_write"}, 32'(rsp_write), 32'(wr));
        check({tag, "_rsp_resp"}, 32'(rsp_resp), 32'(resp));
        check({tag, "_rsp_rdata"}, rsp_rdata, exp_rdata);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        if (wr) wr_exp = sat(wr_exp); else rd_exp = sat(rd_exp);
        if (resp != 2'b00) err_exp = sat(err_exp);
        check({tag, "_rsp_done"}, 32'(rsp_valid), 32'd0);
        check({tag, "_ready_again"}, 32'(cmd_ready), 32'd1);
        check({tag, "_wr_count"}, 32'(wr_count), 32'(wr_exp));
        check({tag, "_rd_count"}, 32'(rd_count), 32'(rd_exp));
        check({tag, "_err_count"}, 32'(err_count), 32'(err_exp));
        if (wr) begin
            check({tag, "_aw_hs"}, 32'(aw_hs - aw0), 32'd1);
            check({tag, "_w_hs"}, 32'(w_hs - w0), 32'd1);
            check({tag, "_b_hs"}, 32'(b_hs - b0), 32'd1);
        end else begin
            check({tag, "_ar_hs"}, 32'(ar_hs - ar0), 32'd1);
            check({tag, "_r_hs"}, 32'(r_hs - r0), 32'd1);
        end
        $display("[TB] %s %s addr=0x%03h data=0x%08h resp=%0d wr=%0d rd=%0d err=%0d", tag,
                 wr ? "WR" : "RD", addr, wr ? data : rsp_rdata, rsp_resp, wr_count, rd_count,
                 err_count);
    endtask

    initial begin
        int snap, n;
        logic [1:0] rr;
        model_reset();
        #2 rst_n = 1'b0;
        #1;
        check("rst_valids", {25'd0, m_axi.AWVALID, m_axi.WVALID, m_axi.BREADY, m_axi.ARVALID,
                             m_axi.RREADY, rsp_valid, cmd_ready}, 32'd0);
        check("rst_counts", {14'd0, wr_count, rd_count, err_count}, 32'd0);
        check("rst_rsp", rsp_rdata | 32'(rsp_resp) | 32'(rsp_write), 32'd0);
        check("rst_bus", m_axi.WDATA | 32'(m_axi.AWADDR) | 32'(m_axi.ARADDR) | 32'(m_axi.WSTRB), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_release_ready", 32'(cmd_ready), 32'd1);

        // basic write/read
        run_cmd(1'b1, 12'h000, 32'h55555555, 4'hF, 2'b00, 0, "wr0");
        run_cmd(1'b0, 12'h000, 32'h0, 4'h0, 2'b00, 0, "rd0");
        run_cmd(1'b1, 12'h004, 32'hAAAAAAAA, 4'hF, 2'b00, 0, "wr4");
        run_cmd(1'b0, 12'h004, 32'h0, 4'h0, 2'b00, 0, "rd4");

        // AWREADY late, then WREADY late
        aw_delay = 3; snap = aw_only_cycles;
        run_cmd(1'b1, 12'h008, 32'h12345678, 4'hF, 2'b00, 0, "aw_late");
        check("aw_late_split", 32'(aw_only_cycles - snap >= 3), 32'd1);
        aw_delay = 0; w_delay = 3; snap = w_only_cycles;
        run_cmd(1'b1, 12'h00C, 32'h9ABCDEF0, 4'hF, 2'b00, 0, "w_late");
        check("w_late_split", 32'(w_only_cycles - snap >= 3), 32'd1);
        w_delay = 0;
        run_cmd(1'b0, 12'h008, 32'h0, 4'h0, 2'b00, 0, "rd8");
        run_cmd(1'b0, 12'h00C, 32'h0, 4'h0, 2'b00, 0, "rdC");

        // response back-pressure, partial strobe, error response
        run_cmd(1'b1, 12'h00C, 32'h11223344, 4'h5, 2'b00, 5, "hold_wr");
        run_cmd(1'b0, 12'h00C, 32'h0, 4'h0, 2'b00, 5, "hold_rd");
        run_cmd(1'b0, 12'hFFC, 32'h0, 4'h0, 2'b00, 0, "stray_rd");
        run_cmd(1'b1, 12'h010, 32'hCAFEF00D, 4'hF, 2'b10, 0, "slverr");

        // randomized commands, delays and error codes
        for (int t = 0; t < 40; t++) begin
            aw_delay = $urandom_range(0, 3); w_delay = $urandom_range(0, 3);
            b_delay  = $urandom_range(0, 3); ar_delay = $urandom_range(0, 3);
            r_delay  = $urandom_range(0, 3);
            n  = $urandom_range(0, 7);
            rr = (n == 0) ? 2'b10 : ((n == 1) ? 2'b11 : 2'b00);
            run_cmd(1'($urandom_range(0, 1)), 12'($urandom_range(0, 15) * 4), $urandom,
                    4'($urandom_range(0, 15)), rr, $urandom_range(0, 2), "rand");
        end
        aw_delay = 0; w_delay = 0; b_delay = 0; ar_delay = 0; r_delay = 0;

        // drive every counter into saturation
        for (int t = 0; t < CMAX + 4; t++) begin
            run_cmd(1'b0, 12'h020, 32'h0, 4'h0, 2'b11, 0, "sat_rd");
            run_cmd(1'b1, 12'h024, 32'h0, 4'hF, 2'b10, 0, "sat_wr");
        end
        check("err_saturated", 32'(err_count), 32'(CMAX));
        check("rd_saturated", 32'(rd_count), 32'(CMAX));

        // reset while AWVALID is high
        aw_delay = 20; w_delay = 20;
        cmd_write = 1'b1; cmd_addr = 12'h004; cmd_wdata = 32'hDEADBEEF; cmd_wstrb = 4'hF;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        while (!m_axi.AWVALID && n < 20) begin @(negedge clk); n++; end
        check("midrst_awvalid_seen", 32'(m_axi.AWVALID), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_drop", {29'd0, m_axi.AWVALID, m_axi.WVALID, cmd_ready}, 32'd0);
        model_reset();
        aw_delay = 0; w_delay = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_cmd(1'b1, 12'h004, 32'h0F0F0F0F, 4'hF, 2'b00, 0, "post_rst_wr");
        run_cmd(1'b0, 12'h004, 32'h0, 4'h0, 2'b00, 0, "post_rst_rd");

        check("bus_stability", 32'(stab_err), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
